// File: rtl/irq_pkg.sv
// Shared constants, bank encodings and FSM state type for the interrupt dispatcher.
package irq_pkg;

  localparam int NCH   = 9;
  localparam int NBANK = 3;

  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;
  localparam logic [1:0] BANK_C = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } state_t;

endpackage

// File: rtl/irq_prio_resolve.sv
// Combinational winner selection: bank A over B over C, lowest channel within a bank.
module irq_prio_resolve #(
  parameter int NCH = 9
) (
  input  logic [NCH-1:0] elig_a,
  input  logic [NCH-1:0] elig_b,
  input  logic [NCH-1:0] elig_c,
  output logic           hit,
  output logic [1:0]     bank,
  output logic [3:0]     chan
);
  import irq_pkg::*;

  // Scanning from the top down lets the lowest set index overwrite the result last.
  function automatic logic [3:0] lowest_set(input logic [NCH-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Pick the first non-empty bank in priority order and report its lowest channel.
  always_comb begin
    hit  = 1'b0;
    bank = BANK_A;
    chan = '0;
    if (|elig_a) begin
      hit  = 1'b1;
      bank = BANK_A;
      chan = lowest_set(elig_a);
    end else if (|elig_b) begin
      hit  = 1'b1;
      bank = BANK_B;
      chan = lowest_set(elig_b);
    end else if (|elig_c) begin
      hit  = 1'b1;
      bank = BANK_C;
      chan = lowest_set(elig_c);
    end
  end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Interrupt dispatcher: sticky pending bits per bank, per-channel enable,
// priority resolution and a valid/ack presentation to the host.
module irq_dispatch_ctrl #(
  parameter int NCH = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_a,
  input  logic [NCH-1:0] req_b,
  input  logic [NCH-1:0] req_c,
  input  logic [NCH-1:0] en,
  input  logic           irq_ack,
  output logic           irq_valid,
  output logic [1:0]     irq_bank,
  output logic [3:0]     irq_chan,
  output logic           pending_any,
  output logic           busy
);
  import irq_pkg::*;

  state_t         state_q, state_d;
  logic [NCH-1:0] pend_a_q, pend_a_d;
  logic [NCH-1:0] pend_b_q, pend_b_d;
  logic [NCH-1:0] pend_c_q, pend_c_d;
  logic [1:0]     irq_bank_q, irq_bank_d;
  logic [3:0]     irq_chan_q, irq_chan_d;

  logic [NCH-1:0] elig_a, elig_b, elig_c;
  logic [NCH-1:0] clr_mask, clr_a, clr_b, clr_c;
  logic           res_hit;
  logic [1:0]     res_bank;
  logic [3:0]     res_chan;

  assign elig_a      = pend_a_q & en;
  assign elig_b      = pend_b_q & en;
  assign elig_c      = pend_c_q & en;
  assign pending_any = |{elig_a, elig_b, elig_c};
  assign busy        = (state_q != IDLE);
  assign irq_bank    = irq_bank_q;
  assign irq_chan    = irq_chan_q;

  irq_prio_resolve #(.NCH(NCH)) u_resolve (
    .elig_a (elig_a),
    .elig_b (elig_b),
    .elig_c (elig_c),
    .hit    (res_hit),
    .bank   (res_bank),
    .chan   (res_chan)
  );

  // Retire the presented bit during CLEAR; a request on the same bit re-sets it.
  always_comb begin
    clr_mask = '0;
    clr_a    = '0;
    clr_b    = '0;
    clr_c    = '0;
    if (state_q == CLEAR) begin
      clr_mask = {{(NCH-1){1'b0}}, 1'b1} << irq_chan_q;
      case (irq_bank_q)
        BANK_A:  clr_a = clr_mask;
        BANK_B:  clr_b = clr_mask;
        BANK_C:  clr_c = clr_mask;
        default: ;
      endcase
    end
    pend_a_d = (pend_a_q & ~clr_a) | req_a;
    pend_b_d = (pend_b_q & ~clr_b) | req_b;
    pend_c_d = (pend_c_q & ~clr_c) | req_c;
  end

  // Handshake FSM; the winner is captured once in EVAL and held through PRESENT.
  always_comb begin
    state_d    = state_q;
    irq_bank_d = irq_bank_q;
    irq_chan_d = irq_chan_q;
    irq_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_any) state_d = EVAL;
      end
      EVAL: begin
        if (res_hit) begin
          irq_bank_d = res_bank;
          irq_chan_d = res_chan;
          state_d    = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        irq_valid = 1'b1;
        if (irq_ack) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pending and winner registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_a_q   <= '0;
      pend_b_q   <= '0;
      pend_c_q   <= '0;
      irq_bank_q <= '0;
      irq_chan_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      pend_c_q   <= pend_c_d;
      irq_bank_q <= irq_bank_d;
      irq_chan_q <= irq_chan_d;
    end
  end

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Directed bench for irq_dispatch_ctrl: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_irq_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req_a, req_b, req_c, en;
  logic       irq_ack;
  logic       irq_valid;
  logic [1:0] irq_bank;
  logic [3:0] irq_chan;
  logic       pending_any;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  irq_dispatch_ctrl #(.NCH(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_c       (req_c),
    .en          (en),
    .irq_ack     (irq_ack),
    .irq_valid   (irq_valid),
    .irq_bank    (irq_bank),
    .irq_chan    (irq_chan),
    .pending_any (pending_any),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle at the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req_a = 9'h001;
    tick();
    req_a = 9'h000;
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== 7'h00)
      $display("[TB] FAIL reset_outputs: got %h expected %h", {irq_valid, irq_bank, irq_chan}, 7'h00);
    else pass_cnt++;
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL reset_pend_busy: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL post_reset_idle: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_single();
    req_b = 9'h010;
    tick();
    req_b = 9'h000;
    total_cnt++;
    if ({pending_any, irq_valid} !== 2'b10)
      $display("[TB] FAIL single_t: got %b expected %b", {pending_any, irq_valid}, 2'b10);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, irq_valid} !== 2'b10)
      $display("[TB] FAIL single_t1: got %b expected %b", {busy, irq_valid}, 2'b10);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd1, 4'd4})
      $display("[TB] FAIL single_present: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd1, 4'd4});
    else pass_cnt++;
    ack_once();
    total_cnt++;
    if ({irq_valid, busy} !== 2'b01)
      $display("[TB] FAIL single_ack_k: got %b expected %b", {irq_valid, busy}, 2'b01);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL single_retired: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    req_a = 9'h080;
    req_b = 9'h004;
    req_c = 9'h001;
    tick();
    req_a = 9'h000;
    req_b = 9'h000;
    req_c = 9'h000;
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd0, 4'd7})
      $display("[TB] FAIL prio_first_a7: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd0, 4'd7});
    else pass_cnt++;
    ack_once();
    tick();
    tick();
    total_cnt++;
    if (irq_valid !== 1'b0)
      $display("[TB] FAIL prio_gap_k2: got %b expected %b", irq_valid, 1'b0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd1, 4'd2})
      $display("[TB] FAIL prio_second_b2: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd1, 4'd2});
    else pass_cnt++;
    ack_once();
    tick();
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd2, 4'd0})
      $display("[TB] FAIL prio_third_c0: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd2, 4'd0});
    else pass_cnt++;
    ack_once();
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL prio_drained: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_mask();
    en    = 9'h1F7;
    req_a = 9'h008;
    req_c = 9'h020;
    tick();
    req_a = 9'h000;
    req_c = 9'h000;
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd2, 4'd5})
      $display("[TB] FAIL mask_c5_first: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd2, 4'd5});
    else pass_cnt++;
    ack_once();
    tick();
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL mask_hidden: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
    en = 9'h1FF;
    #1;
    total_cnt++;
    if (pending_any !== 1'b1)
      $display("[TB] FAIL mask_kept: got %b expected %b", pending_any, 1'b1);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd0, 4'd3})
      $display("[TB] FAIL mask_a3_next: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd0, 4'd3});
    else pass_cnt++;
    ack_once();
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL mask_drained: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_no_preempt();
    req_c = 9'h100;
    tick();
    req_c = 9'h000;
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd2, 4'd8})
      $display("[TB] FAIL nopre_c8: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd2, 4'd8});
    else pass_cnt++;
    req_a = 9'h001;
    tick();
    req_a = 9'h000;
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd2, 4'd8})
      $display("[TB] FAIL nopre_hold: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd2, 4'd8});
    else pass_cnt++;
    en = 9'h0FF;
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd2, 4'd8})
      $display("[TB] FAIL nopre_masked_hold: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd2, 4'd8});
    else pass_cnt++;
    ack_once();
    tick();
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd0, 4'd0})
      $display("[TB] FAIL nopre_then_a0: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd0, 4'd0});
    else pass_cnt++;
    en = 9'h1FF;
    ack_once();
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL nopre_c8_retired: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    req_a = 9'h002;
    tick();
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd0, 4'd1})
      $display("[TB] FAIL held_first: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd0, 4'd1});
    else pass_cnt++;
    for (int r = 0; r < 2; r++) begin
      ack_once();
      total_cnt++;
      if (irq_valid !== 1'b0)
        $display("[TB] FAIL held_drop_%0d: got %b expected %b", r, irq_valid, 1'b0);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (pending_any !== 1'b1)
        $display("[TB] FAIL held_repend_%0d: got %b expected %b", r, pending_any, 1'b1);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd0, 4'd1})
        $display("[TB] FAIL held_again_%0d: got %h expected %h", r, {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd0, 4'd1});
      else pass_cnt++;
    end
    req_a = 9'h000;
    ack_once();
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL held_released: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_ack_outside();
    irq_ack = 1'b1;
    req_b   = 9'h100;
    tick();
    req_b = 9'h000;
    tick();
    tick();
    irq_ack = 1'b0;
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd1, 4'd8})
      $display("[TB] FAIL ackout_present: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd1, 4'd8});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd1, 4'd8})
      $display("[TB] FAIL ackout_still: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd1, 4'd8});
    else pass_cnt++;
    ack_once();
    tick();
    total_cnt++;
    if ({pending_any, busy} !== 2'b00)
      $display("[TB] FAIL ackout_drained: got %b expected %b", {pending_any, busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_b = 9'h040;
    req_c = 9'h002;
    tick();
    req_b = 9'h000;
    req_c = 9'h000;
    tick();
    tick();
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan} !== {1'b1, 2'd1, 4'd6})
      $display("[TB] FAIL rstmid_b6: got %h expected %h", {irq_valid, irq_bank, irq_chan}, {1'b1, 2'd1, 4'd6});
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({irq_valid, irq_bank, irq_chan, pending_any, busy} !== 9'h000)
      $display("[TB] FAIL rstmid_cleared: got %h expected %h", {irq_valid, irq_bank, irq_chan, pending_any, busy}, 9'h000);
    else pass_cnt++;
    ack_once();
    total_cnt++;
    if ({irq_valid, busy, pending_any} !== 3'b000)
      $display("[TB] FAIL rstmid_late_ack: got %b expected %b", {irq_valid, busy, pending_any}, 3'b000);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({irq_valid, busy} !== 2'b00)
      $display("[TB] FAIL rstmid_idle: got %b expected %b", {irq_valid, busy}, 2'b00);
    else pass_cnt++;
  endtask

  initial begin
    rst     = 1'b1;
    req_a   = '0;
    req_b   = '0;
    req_c   = '0;
    en      = 9'h1FF;
    irq_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_preempt();
    test_back_to_back();
    test_ack_outside();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
